uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
Memory-mapped serial transmitter that carries program output out of the RISC-V Computer. The simulation top drives clock and reset into the Computer; this block is the outbound path. The core issues word-wide stores and loads to a 2-word register window. Bytes are buffered in a small FIFO and shifted out on `tx` as 8N1 frames, so a bench or a line monitor can capture them.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit. Must be ≥2.
FIFO_DEPTH, 4, byte entries. Must be a power of 2 and ≥2.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clock
we     input  1  store strobe, valid for one cycle
re     input  1  load strobe, valid for one cycle
addr   input  1  register select: 0 = TXDATA, 1 = STATUS
wdata  input  32  store data
rdata  output 32  load data, registered
tx     output 1  serial line, idle high

Behaviour:
- Reset (reset==0 at an edge):
  - tx=1, rdata=0.
  - FIFO empty (count=0, pointers 0).
  - Serializer state=IDLE.
  - overflow=0.
  - Reset mid-frame aborts the frame; tx returns high at that same edge.
- Register map:
  - TXDATA write: pushes wdata[7:0]; wdata[31:8] ignored. TXDATA read returns 0.
  - STATUS read layout:
    - bit0 full (count==FIFO_DEPTH)
    - bit1 empty (count==0)
    - bit2 busy (state!=IDLE)
    - bit3 overflow (sticky)
    - bits[7:4] count
    - bits[31:8] 0
  - STATUS write: wdata[3]==1 clears overflow; all other bits ignored.
- Read timing: re at edge k loads rdata at edge k. The value reflects state before edge k. rdata holds until the next re.
- Push rules:
  - Accepted if pre-edge count < FIFO_DEPTH.
  - If full, the byte is dropped and overflow is set, even if a pop occurs at the same edge.
  - A push and a pop at the same edge: count is unchanged, data is preserved.
- FIFO: circular buffer; pointers wrap modulo FIFO_DEPTH.
- we and re at the same edge: both are performed. re samples the pre-edge status.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - Bit counter runs 0..CLKS_PER_BIT-1; bit index runs 0..7.
- IDLE:
  - tx=1.
  - If FIFO is non-empty (pre-edge): pop the head into the shift register, set tx=0, go to START.
  - A byte pushed at edge k into an empty FIFO is popped at edge k+1, so tx falls at edge k+1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shift[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, LSB first.
  - After bit 7 completes: tx=1, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - Then, if FIFO is non-empty: pop, tx=0, go to START (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- tx is driven from a flop only and never glitches.
- Pushes during a frame never disturb the shift register.

Test Plan:
1. Reset low 2 cycles, release; write 0x55 to TXDATA at edge k → tx is 0 from k+1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then stop 1 for 4 cycles; busy=1 over [k+1, k+41), then 0.
2. Write 0x41 then 0x0A on consecutive cycles → two frames back-to-back, 80 cycles total with no idle cycle between the stop and the second start; STATUS empty=1 after the second pop.
3. During the first frame, write 5 bytes with FIFO_DEPTH=4 (1 byte popped already) → all 5 accepted; one further write → dropped, STATUS reads 0x0000_000D (full, busy, overflow, count=0).
   - Correction: the expected value is count=4 → 0x4D.
   - Write STATUS with wdata=0x8 → overflow=0.
4. Read STATUS immediately after reset → rdata=0x0000_0002. Read TXDATA → 0.
5. Assert reset at cycle 15 of a frame for one cycle → tx=1 at that edge, STATUS=0x2 afterwards, and no residual bits are emitted.
6. Write to a full FIFO at the same edge the serializer pops → write dropped, overflow=1, count goes from 4 to 3.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: two-register MMIO window feeding a byte FIFO
// and an 8N1 serializer on tx.
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic        re,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n, overflow, pop, push, drop;
    logic          full, empty, bit_end;
    logic [31:0]   status;
    logic          unused_wdata;

    assign unused_wdata = &{1'b0, wdata[31:8]};
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign push    = we && !addr && !full;
    assign drop    = we && !addr && full;
    assign bit_end = bcnt == BW'(CLKS_PER_BIT - 1);
    assign status  = {24'd0, 4'(count), overflow,
                      state != IDLE, empty, full};

    always_comb begin
        state_n = state;
        bcnt_n  = bcnt + 1'b1;
        bidx_n  = bidx;
        shift_n = shift;
        tx_n    = tx;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                tx_n   = 1'b1;
                bcnt_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rptr];
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bcnt_n  = '0;
                    bidx_n  = '0;
                    tx_n    = shift[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bcnt_n = '0;
                    if (bidx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bidx_n  = bidx + 1'b1;
                        shift_n = shift >> 1;
                        tx_n    = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    bcnt_n = '0;
                    if (!empty) begin
                        // back-to-back frame, no idle gap
                        pop     = 1'b1;
                        shift_n = mem[rptr];
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            bcnt  <= '0;
            bidx  <= '0;
            shift <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            bcnt  <= bcnt_n;
            bidx  <= bidx_n;
            shift <= shift_n;
            tx    <= tx_n;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rdata    <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (we && addr && wdata[3])
                overflow <= 1'b0;
            if (re)
                rdata <= addr ? status : 32'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= wdata[7:0];
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed + random stimulus against a
// frame-level reference model of the MMIO UART transmitter.
module tb_uart_tx_mmio;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic        addr  = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;

    uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .we(we), .re(re),
        .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  q[$];
    logic [7:0]  m_byte = '0;
    int          m_pos  = 0;
    bit          m_busy = 0;
    bit          m_ovf  = 0;
    logic [31:0] m_rdata = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // expected line level from position inside the current frame
    function automatic logic m_tx();
        if (!m_busy)          return 1'b1;
        if (m_pos < CPB)      return 1'b0;
        if (m_pos < 9 * CPB)  return m_byte[(m_pos - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic model_step();
        int          pre_cnt;
        logic [31:0] st;
        if (!reset) begin
            q.delete();
            m_busy  = 0;
            m_pos   = 0;
            m_ovf   = 0;
            m_rdata = '0;
            return;
        end
        pre_cnt = q.size();
        st = {24'd0, 4'(pre_cnt), m_ovf, m_busy,
              pre_cnt == 0, pre_cnt == DEPTH};
        if (re) m_rdata = addr ? st : 32'd0;
        if ((!m_busy || m_pos == FRAME - 1) && pre_cnt > 0) begin
            m_byte = q.pop_front();
            m_pos  = 0;
            m_busy = 1;
        end else if (m_busy) begin
            m_pos++;
            if (m_pos == FRAME) m_busy = 0;
        end
        if (we && !addr) begin
            if (pre_cnt < DEPTH) q.push_back(wdata[7:0]);
            else m_ovf = 1;
        end
        if (we && addr && wdata[3]) m_ovf = 0;
    endtask

    task automatic cyc(input logic r, input logic w, input logic rd,
                       input logic a, input logic [31:0] d);
        reset = r;
        we    = w;
        re    = rd;
        addr  = a;
        wdata = d;
        @(posedge clock);
        model_step();
        #1;
        check("tx", 32'(tx), 32'(m_tx()));
        check("rdata", rdata, m_rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0);
    endtask

    task automatic wr_reg(input logic a, input logic [31:0] d);
        cyc(1, 1, 0, a, d);
    endtask

    task automatic rd_reg(input logic a);
        cyc(1, 0, 1, a, 0);
    endtask

    initial begin
        int guard;
        logic r, w, rd, a;

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        rd_reg(1);
        check("rst_status", rdata, 32'h2);
        rd_reg(0);
        check("txdata_rd", rdata, 32'h0);

        wr_reg(0, 32'hFFFF_FF55);
        idle(FRAME + 5);

        wr_reg(0, 32'h41);
        wr_reg(0, 32'h0A);
        idle(45);
        rd_reg(1);
        check("b2b_status", rdata, 32'h6);
        idle(FRAME);

        wr_reg(0, 32'hA5);
        idle(1);
        repeat (DEPTH) wr_reg(0, $urandom);
        wr_reg(0, 32'hFF);
        rd_reg(1);
        check("full_status", rdata, 32'h4D);
        wr_reg(1, 32'h8);
        rd_reg(1);
        check("ovf_clear", rdata, 32'h45);

        guard = 0;
        while (!(m_busy && m_pos == FRAME - 1) && guard < 100) begin
            idle(1);
            guard++;
        end
        check("pop_wait", 32'(m_pos), 32'(FRAME - 1));
        wr_reg(0, 32'h77);
        rd_reg(1);
        check("full_pop", rdata, 32'h3C);
        idle(5 * FRAME);

        wr_reg(0, 32'h3C);
        guard = 0;
        while (!(m_busy && m_pos == 15) && guard < 100) begin
            idle(1);
            guard++;
        end
        check("mid_wait", 32'(m_pos), 32'd15);
        cyc(0, 0, 0, 0, 0);
        check("mid_rst_tx", 32'(tx), 32'd1);
        rd_reg(1);
        check("mid_rst_status", rdata, 32'h2);
        idle(50);

        repeat (3000) begin
            r  = $urandom_range(0, 499) != 0;
            w  = $urandom_range(0, 5) == 0;
            rd = $urandom_range(0, 3) == 0;
            a  = $urandom_range(0, 3) == 0;
            cyc(r, w, rd, a, $urandom);
        end
        idle(6 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
